order_gen: RTL and testbench

ORDER_GEN -- requirements
Module: order_gen

---
 rtl/order_gen.sv | 169 ++++++++++++++++
 tb/tb_order_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_gen.sv
// Purpose : turns a signed Q16.16 trading signal into buy/sell order words, gated by risk inputs.
// Latency : order word valid the cycle after the accepting edge; cooldown of COOLDOWN cycles follows.
// Backpress: in_ready drops while an order is held or cooling; the order holds until ord_ready.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream signal word handshake (signal_in, allow_trade, kill_switch)
//   ord_valid/ord_ready : downstream order handshake (ord_side, ord_qty, ord_id)
//   halted              : high while the kill switch has latched the block
//   rearm               : one-cycle pulse that releases the halted state
module order_gen #(
    parameter logic signed [31:0] THRESH   = 32'sh0000_4000,
    parameter int unsigned        COOLDOWN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] signal_in,
    input  logic               allow_trade,
    input  logic               kill_switch,
    output logic               ord_valid,
    input  logic               ord_ready,
    output logic               ord_side,
    output logic [15:0]        ord_qty,
    output logic [15:0]        ord_id,
    output logic               halted,
    input  logic               rearm
);

    // Counter wide enough to hold COOLDOWN; at least one bit when cooldown is disabled.
    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CNT_W-1:0]   COOL_LOAD  = CNT_W'(COOLDOWN);
    localparam logic signed [31:0] NEG_THRESH = -THRESH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        COOL   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             ord_valid_q;
    logic             ord_side_q;
    logic [15:0]      ord_qty_q;
    logic [15:0]      ord_id_q;
    logic             halted_q;
    logic [CNT_W-1:0] cool_cnt_q;

    logic        accept;
    logic        is_buy;
    logic        is_sell;
    logic [31:0] abs_d;
    logic [15:0] abs_int_d;
    logic [15:0] qty_d;

    assign accept  = in_valid && in_ready_q;
    assign is_buy  = (signal_in >= THRESH);
    assign is_sell = (signal_in <= NEG_THRESH);

    // Magnitude of the signal; the most negative value has no positive
    // counterpart in 32 bits, so it saturates to the largest positive value.
    always_comb begin
        abs_d = 32'(signal_in);
        if (signal_in[31]) begin
            if (signal_in == 32'sh8000_0000) begin
                abs_d = 32'h7FFF_FFFF;
            end else begin
                abs_d = 32'(-signal_in);
            end
        end
    end

    // Integer part of the magnitude; sub-unit signals still trade one lot.
    assign abs_int_d = 16'(abs_d >> 16);
    assign qty_d     = (abs_int_d == 16'd0) ? 16'd1 : abs_int_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            ord_valid_q <= 1'b0;
            ord_side_q  <= 1'b0;
            ord_qty_q   <= 16'd0;
            ord_id_q    <= 16'd0;
            halted_q    <= 1'b0;
            cool_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (kill_switch) begin
                            // Kill dominates: no order regardless of permit or signal.
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else if (allow_trade && is_buy) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            ord_valid_q <= 1'b1;
                            ord_side_q  <= 1'b1;
                            ord_qty_q   <= qty_d;
                        end else if (allow_trade && is_sell) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            ord_valid_q <= 1'b1;
                            ord_side_q  <= 1'b0;
                            ord_qty_q   <= qty_d;
                        end
                        // Anything else is consumed and dropped.
                    end
                end

                HOLD: begin
                    // Order word stays frozen until the downstream takes it.
                    if (ord_ready) begin
                        ord_valid_q <= 1'b0;
                        ord_id_q    <= ord_id_q + 16'd1;
                        if (COOLDOWN == 0) begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q    <= COOL;
                            cool_cnt_q <= COOL_LOAD;
                        end
                    end
                end

                COOL: begin
                    // Leave on the edge where the count reaches zero, so
                    // exactly COOLDOWN cycles are spent here.
                    if (cool_cnt_q <= CNT_W'(1)) begin
                        cool_cnt_q <= '0;
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        cool_cnt_q <= cool_cnt_q - CNT_W'(1);
                    end
                end

                HALTED: begin
                    // Words accepted here are discarded, including one
                    // arriving together with the rearm pulse.
                    if (rearm) begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    ord_valid_q <= 1'b0;
                    halted_q    <= 1'b0;
                    cool_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign ord_valid = ord_valid_q;
    assign ord_side  = ord_side_q;
    assign ord_qty   = ord_qty_q;
    assign ord_id    = ord_id_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_order_gen.sv
// Purpose : directed self-checking bench for order_gen (THRESH=+0.25, COOLDOWN=4).
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpress: ord_ready is driven per step to exercise holding and release of orders.
module tb_order_gen;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] signal_in;
    logic               allow_trade;
    logic               kill_switch;
    logic               ord_valid;
    logic               ord_ready;
    logic               ord_side;
    logic [15:0]        ord_qty;
    logic [15:0]        ord_id;
    logic               halted;
    logic               rearm;

    int n_tests = 0;
    int n_fail  = 0;

    order_gen #(
        .THRESH  (32'sh0000_4000),
        .COOLDOWN(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .signal_in  (signal_in),
        .allow_trade(allow_trade),
        .kill_switch(kill_switch),
        .ord_valid  (ord_valid),
        .ord_ready  (ord_ready),
        .ord_side   (ord_side),
        .ord_qty    (ord_qty),
        .ord_id     (ord_id),
        .halted     (halted),
        .rearm      (rearm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the block is ready for input again.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $error("FAIL wait_ready: in_ready still low after %0d cycles", n);
        end
    endtask

    initial begin
        int low_cnt;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        signal_in   = 32'sh0;
        allow_trade = 1'b0;
        kill_switch = 1'b0;
        ord_ready   = 1'b0;
        rearm       = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ord_valid", 32'(ord_valid), 32'd0);
        check("rst_ord_id", 32'(ord_id), 32'h0000);
        check("rst_ord_qty", 32'(ord_qty), 32'h0000);
        check("rst_ord_side", 32'(ord_side), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;

        // +2.5 buy, ord_ready high: 1 HOLD + 4 COOL cycles without in_ready
        in_valid    = 1'b1;
        signal_in   = 32'sh0002_8000;
        allow_trade = 1'b1;
        ord_ready   = 1'b1;
        tick();
        check("buy_valid", 32'(ord_valid), 32'd1);
        check("buy_side", 32'(ord_side), 32'd1);
        check("buy_qty", 32'(ord_qty), 32'd2);
        check("buy_id", 32'(ord_id), 32'h0000);
        check("buy_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        low_cnt  = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_ready) break;
            low_cnt++;
        end
        check("busy_cycles", 32'(low_cnt), 32'd5);
        check("buy_id_after", 32'(ord_id), 32'h0001);
        check("buy_valid_after", 32'(ord_valid), 32'd0);

        // -0.3 sell with qty forced to 1
        in_valid  = 1'b1;
        signal_in = 32'shFFFF_B333;
        tick();
        check("sell_valid", 32'(ord_valid), 32'd1);
        check("sell_side", 32'(ord_side), 32'd0);
        check("sell_qty", 32'(ord_qty), 32'd1);
        check("sell_id", 32'(ord_id), 32'h0001);
        in_valid = 1'b0;
        wait_ready();

        // +0.2 is below threshold: dropped
        in_valid  = 1'b1;
        signal_in = 32'sh0000_3333;
        tick();
        check("small_valid", 32'(ord_valid), 32'd0);
        check("small_in_ready", 32'(in_ready), 32'd1);
        check("small_id", 32'(ord_id), 32'h0002);

        // Stall downstream for 5 cycles; the order must not move
        ord_ready = 1'b0;
        signal_in = 32'sh0003_0000;
        tick();
        check("stall_valid0", 32'(ord_valid), 32'd1);
        check("stall_qty0", 32'(ord_qty), 32'd3);
        signal_in = 32'shFFF0_0000;   // offered while busy; must not be taken
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(ord_valid), 32'd1);
            check("stall_side", 32'(ord_side), 32'd1);
            check("stall_qty", 32'(ord_qty), 32'd3);
            check("stall_id", 32'(ord_id), 32'h0002);
        end
        in_valid  = 1'b0;
        ord_ready = 1'b1;
        tick();
        check("stall_release_valid", 32'(ord_valid), 32'd0);
        check("stall_release_id", 32'(ord_id), 32'h0003);
        wait_ready();

        // allow_trade=0 drops the word
        in_valid    = 1'b1;
        allow_trade = 1'b0;
        signal_in   = 32'sh0005_0000;
        tick();
        check("noallow_valid", 32'(ord_valid), 32'd0);
        check("noallow_halted", 32'(halted), 32'd0);

        // Kill switch latches HALTED, no order
        allow_trade = 1'b1;
        kill_switch = 1'b1;
        tick();
        check("kill_halted", 32'(halted), 32'd1);
        check("kill_valid", 32'(ord_valid), 32'd0);
        check("kill_in_ready", 32'(in_ready), 32'd1);
        kill_switch = 1'b0;
        tick();
        check("halted_discard_valid", 32'(ord_valid), 32'd0);
        check("halted_stays", 32'(halted), 32'd1);

        // Rearm with a same-cycle word: word discarded
        rearm = 1'b1;
        tick();
        check("rearm_halted", 32'(halted), 32'd0);
        check("rearm_discard_valid", 32'(ord_valid), 32'd0);
        rearm = 1'b0;
        tick();
        check("post_rearm_valid", 32'(ord_valid), 32'd1);
        check("post_rearm_qty", 32'(ord_qty), 32'd5);
        check("post_rearm_id", 32'(ord_id), 32'h0003);
        in_valid = 1'b0;
        wait_ready();
        check("post_rearm_id_after", 32'(ord_id), 32'h0004);

        // Asynchronous reset in the middle of HOLD
        ord_ready = 1'b0;
        in_valid  = 1'b1;
        signal_in = 32'sh0001_0000;
        tick();
        check("pre_rst_valid", 32'(ord_valid), 32'd1);
        check("pre_rst_id", 32'(ord_id), 32'h0004);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ord_valid), 32'd0);
        check("async_rst_id", 32'(ord_id), 32'h0000);
        check("async_rst_qty", 32'(ord_qty), 32'h0000);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;

        // First edge after reset release accepts
        in_valid  = 1'b1;
        ord_ready = 1'b1;
        tick();
        check("first_accept_valid", 32'(ord_valid), 32'd1);
        check("first_accept_qty", 32'(ord_qty), 32'd1);
        check("first_accept_id", 32'(ord_id), 32'h0000);
        in_valid = 1'b0;
        wait_ready();

        // Preload the sequence counter to 0xFFFF, then wrap it
        force dut.ord_id_q = 16'hFFFF;
        #1;
        release dut.ord_id_q;
        #1;
        check("preload_id", 32'(ord_id), 32'hFFFF);
        in_valid  = 1'b1;
        signal_in = 32'sh8000_0000;
        tick();
        check("sat_valid", 32'(ord_valid), 32'd1);
        check("sat_side", 32'(ord_side), 32'd0);
        check("sat_qty", 32'(ord_qty), 32'h7FFF);
        check("sat_id", 32'(ord_id), 32'hFFFF);
        in_valid = 1'b0;
        tick();
        check("wrap_id", 32'(ord_id), 32'h0000);
        wait_ready();

        // rearm outside HALTED is ignored
        rearm = 1'b1;
        tick();
        check("stray_rearm_halted", 32'(halted), 32'd0);
        check("stray_rearm_in_ready", 32'(in_ready), 32'd1);
        rearm = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
